// File: rtl/clk_period_meter_pkg.sv
// Shared types and defaults for the clock period meter.
package clk_meter_pkg;

    localparam int CNT_W_DEF    = 16;
    localparam int LOCK_CNT_DEF = 4;
    // The lock counter is 4 bits wide, so LOCK_CNT can be at most 15.
    localparam int LOCK_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_EDGE,
        ST_MEASURE
    } meter_state_e;

endpackage

// File: rtl/clk_period_meter_sync_edge_det.sv
// Synchronizer chain for an asynchronous input, followed by a rising-edge detector.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sig_i,
    output logic s_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_prev_q;

    // Shift the input through the synchronizer and keep the previous synchronized value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= '0;
            s_prev_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], sig_i};
            s_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s_o    = sync_q[SYNC_STAGES-1];
    assign rise_o = s_o & ~s_prev_q;

endmodule

// File: rtl/clk_period_meter.sv
// Clock period / high-time meter with lock detection against an expected divide ratio.
// Define CLK_METER_DUTY_EN to build the high-time counter. Without it, high_time is tied to 0.
module clk_period_meter
    import clk_meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CNT    = LOCK_CNT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sig_in,
    input  logic [CNT_W-1:0] expected_div,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             timeout,
    output logic             locked
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [LOCK_W-1:0] LOCK_TGT = LOCK_W'(LOCK_CNT);
    localparam logic [LOCK_W-1:0] LOCK_ONE = LOCK_W'(1);

    logic s, rise;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .reset  (reset),
        .sig_i  (sig_in),
        .s_o    (s),
        .rise_o (rise)
    );

    meter_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic              mv_q, mv_d;
    logic              to_q, to_d;
    logic              locked_q, locked_d;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [LOCK_W-1:0] lock_nxt;
    logic              match;
`ifdef CLK_METER_DUTY_EN
    logic [CNT_W-1:0]  hcnt_q, hcnt_d;
    logic [CNT_W-1:0]  high_q, high_d;
`endif

    // A zero expected_div switches lock checking off.
    assign match    = (cnt_q == expected_div) && (expected_div != '0);
    assign lock_nxt = (lock_cnt_q == LOCK_TGT) ? LOCK_TGT : lock_cnt_q + LOCK_ONE;

    // Next-state logic: the FSM plus the counters it steers.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        mv_d       = 1'b0;
        to_d       = 1'b0;
        locked_d   = locked_q;
        lock_cnt_d = lock_cnt_q;
`ifdef CLK_METER_DUTY_EN
        hcnt_d     = hcnt_q;
        high_d     = high_q;
`endif
        if (!enable) begin
            // Dropping enable discards any partial period and overrides rise and saturation.
            state_d    = ST_IDLE;
            cnt_d      = '0;
            locked_d   = 1'b0;
            lock_cnt_d = '0;
`ifdef CLK_METER_DUTY_EN
            hcnt_d     = '0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    cnt_d      = '0;
                    locked_d   = 1'b0;
                    lock_cnt_d = '0;
`ifdef CLK_METER_DUTY_EN
                    hcnt_d     = '0;
`endif
                    state_d    = ST_WAIT_EDGE;
                end
                ST_WAIT_EDGE: begin
                    // The first rise only opens a period; nothing is reported yet.
                    if (rise) begin
                        cnt_d   = CNT_ONE;
`ifdef CLK_METER_DUTY_EN
                        hcnt_d  = CNT_ONE;
`endif
                        state_d = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (cnt_q == CNT_MAX) begin
                        // A saturated counter wins over a coincident rise; that period is discarded.
                        to_d       = 1'b1;
                        locked_d   = 1'b0;
                        lock_cnt_d = '0;
                        state_d    = ST_WAIT_EDGE;
                    end else if (rise) begin
                        period_d = cnt_q;
                        mv_d     = 1'b1;
                        cnt_d    = CNT_ONE;
`ifdef CLK_METER_DUTY_EN
                        high_d   = hcnt_q;
                        hcnt_d   = CNT_ONE;
`endif
                        if (match) begin
                            lock_cnt_d = lock_nxt;
                            locked_d   = (lock_nxt == LOCK_TGT);
                        end else begin
                            lock_cnt_d = '0;
                            locked_d   = 1'b0;
                        end
                    end else begin
                        cnt_d  = cnt_q + CNT_ONE;
`ifdef CLK_METER_DUTY_EN
                        hcnt_d = hcnt_q + CNT_W'(s);
`endif
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            period_q   <= '0;
            mv_q       <= 1'b0;
            to_q       <= 1'b0;
            locked_q   <= 1'b0;
            lock_cnt_q <= '0;
`ifdef CLK_METER_DUTY_EN
            hcnt_q     <= '0;
            high_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            mv_q       <= mv_d;
            to_q       <= to_d;
            locked_q   <= locked_d;
            lock_cnt_q <= lock_cnt_d;
`ifdef CLK_METER_DUTY_EN
            hcnt_q     <= hcnt_d;
            high_q     <= high_d;
`endif
        end
    end

    assign period     = period_q;
    assign meas_valid = mv_q;
    assign timeout    = to_q;
    assign locked     = locked_q;
`ifdef CLK_METER_DUTY_EN
    assign high_time  = high_q;
`else
    logic unused_s;
    assign unused_s   = s;
    assign high_time  = '0;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: pattern table plus hand-written corner sequences.
module tb_clk_period_meter;

`ifdef CLK_METER_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        sig_in = 1'b0;
    logic [15:0] expected_div = '0;
    logic [15:0] period, high_time;
    logic        meas_valid, timeout, locked;

    logic        en4 = 1'b0;
    logic        sig4 = 1'b0;
    logic [3:0]  ed4 = '0;
    logic [3:0]  period4, high4;
    logic        mv4, to4, lk4;

    int checks = 0;
    int errors = 0;
    int gen_P = 0;
    int gen_H = 0;

    always #5 clk = ~clk;

    clk_period_meter dut (
        .clk(clk), .reset(reset), .enable(enable), .sig_in(sig_in),
        .expected_div(expected_div), .period(period), .high_time(high_time),
        .meas_valid(meas_valid), .timeout(timeout), .locked(locked)
    );

    clk_period_meter #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .enable(en4), .sig_in(sig4),
        .expected_div(ed4), .period(period4), .high_time(high4),
        .meas_valid(mv4), .timeout(to4), .locked(lk4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Periodic waveform source: H cycles high then P-H low, changed on negedges.
    initial begin : gen
        int p, h;
        forever begin
            p = gen_P;
            h = gen_H;
            if (p == 0) begin
                sig_in = 1'b0;
                @(negedge clk);
            end else begin
                for (int i = 0; i < p; i++) begin
                    sig_in = (i < h);
                    @(negedge clk);
                end
            end
        end
    end

    typedef struct {
        int P; int H; int ed; int nvalid; int exp_p; int exp_h; int lock_at; bit rst;
    } row_t;
    row_t rows[5];

    task automatic reset_mid_cycle();
        gen_P = 0;
        repeat (8) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("rst period", period, 0);
        check("rst high_time", high_time, 0);
        check("rst meas_valid", meas_valid, 0);
        check("rst timeout", timeout, 0);
        check("rst locked", locked, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic observe(input int nvalid, input int exp_p, input int exp_h, input int lock_at);
        int k, last, cyc;
        k = 0; last = -1; cyc = 0;
        while (k < nvalid && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            if (timeout) check("spurious timeout", timeout, 0);
            if (meas_valid) begin
                k++;
                check("period", period, exp_p);
                check("high_time", high_time, DUTY ? exp_h : 0);
                check("locked", locked, (lock_at != 0 && k >= lock_at));
                if (last >= 0) check("valid spacing", cyc - last, exp_p);
                last = cyc;
            end
        end
        if (k < nvalid) check("valid count", k, nvalid);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int seen;
        rows[0] = '{2, 1, 2, 6, 2, 1, 4, 1'b1};
        rows[1] = '{6, 3, 6, 5, 6, 3, 4, 1'b1};
        rows[2] = '{5, 1, 4, 6, 5, 1, 0, 1'b1};
        rows[3] = '{5, 1, 5, 5, 5, 1, 4, 1'b0};
        rows[4] = '{4, 2, 4, 5, 4, 2, 4, 1'b1};

        #2 reset = 1'b1;
        #1;
        check("init period", period, 0);
        check("init meas_valid", meas_valid, 0);
        check("init locked", locked, 0);
        check("init timeout4", to4, 0);
        en4 = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Saturation on the 4-bit instance: one pulse, then silence.
        repeat (3) @(posedge clk);
        @(negedge clk);
        sig4 = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            @(posedge clk);
            #1;
            check("sat timeout4", to4, (c == 18));
            check("sat meas_valid4", mv4, 0);
            if (c == 18) check("sat locked4", lk4, 0);
            @(negedge clk);
            if (c == 1) sig4 = 1'b0;
        end
        // Back in WAIT_EDGE: the next rise only opens a period, the one after reports it.
        sig4 = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            check("post-sat meas_valid4", mv4, (c == 9));
            if (c == 9) check("post-sat period4", period4, 6);
            @(negedge clk);
            if (c == 1) sig4 = 1'b0;
            if (c == 6) sig4 = 1'b1;
            if (c == 7) sig4 = 1'b0;
        end

        enable = 1'b1;
        for (int r = 0; r < 5; r++) begin
            if (rows[r].rst) reset_mid_cycle();
            expected_div = 16'(rows[r].ed);
            gen_H = rows[r].H;
            gen_P = rows[r].P;
            observe(rows[r].nvalid, rows[r].exp_p, rows[r].exp_h, rows[r].lock_at);
        end

        // Locked on div4; drop enable for one cycle just after a result.
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 2) enable = 1'b0;
            if (c == 3) enable = 1'b1;
            @(posedge clk);
            #1;
            check("en-drop meas_valid", meas_valid, (c == 8));
            if (c >= 2) check("en-drop locked", locked, 0);
            if (c == 8) check("en-drop period", period, 4);
        end

        // Async reset in the middle of a measurement, then a clean restart.
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk);
            #1;
            seen = meas_valid;
        end
        check("pre-reset result seen", seen, 1);
        #2 reset = 1'b1;
        gen_P = 0;
        #1;
        check("async rst period", period, 0);
        check("async rst meas_valid", meas_valid, 0);
        check("async rst locked", locked, 0);
        check("async rst high_time", high_time, 0);
        repeat (6) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        gen_H = 2;
        gen_P = 4;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            check("restart meas_valid", meas_valid, (c == 7));
            if (c == 7) begin
                check("restart period", period, 4);
                check("restart locked", locked, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
